pixel_sensor_array: RTL and testbench
=====================================

# pixel_sensor_array

Digital behavioural model of a small image-sensor pixel array with its column ADC, packaged as one synthesizable block. Each pixel integrates exposure pulses into a fixed-point "photo voltage". A shared ramp counter then digitises all pixels single-slope style, and one row is read out at a time on an 8-bit bus. It sits between the sensor sequencer, which drives erase/expose/read and the ramp/bias strobes, and the readout datapath.

## Interface
- `ROWS`, default 2: number of pixels, one per row; minimum 2.
- `DV_PIXEL_Q8`, default 128: photocurrent per exposure pulse, as a 0.8 fraction (128 = 0.5 LSB). Valid range 0–255.
- `RP_W`, default `$clog2(ROWS)`: row_pointer width.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `ana_bias1` input 1: exposure strobe; integrates when high at a clk edge.
- `ana_ramp` input 1: conversion strobe; advances the ramp when high at a clk edge, clears the ramp when low.
- `ana_reset` input 1: erase enable; erase has no effect while low.
- `erase` input 1: clears all pixels.
- `expose` input 1: exposure window.
- `read` input 1: readout enable.
- `row_pointer` input RP_W: selects the row to read.
- `out_data` output 8: registered read data.

## Operation
Per-pixel state:
- `acc`: 16-bit, 8.8 fixed point.
- `sample`: 8 bits.
- `done`: 1 bit.

Shared state:
- `ramp`: 8-bit counter.

Per rising clk edge, priority in this order:
- **Erase.** When `erase && ana_reset`: every `acc`=0, `sample`=0, `done`=0, `ramp`=0. Expose and ramp are ignored that cycle.
- **Expose.** When `expose && ana_bias1`: `acc += DV_PIXEL_Q8`, saturating at 0xFFFF.
- **Convert.** When `ana_ramp`=1, for each pixel with `done`=0 and `ramp >= acc[15:8]`: `sample <= ramp`, `done <= 1`. The comparison uses the pre-increment `ramp`. Then `ramp <= ramp+1`, saturating at 255.
- **Ramp clear.** When `ana_ramp`=0: `ramp <= 0`. `sample` and `done` hold.
- **Read.** `out_data <= read ? sample[row_pointer] : 8'h00`.
  - If `row_pointer >= ROWS`, the result is 8'h00.
  - `read` is independent of the other modes; it may overlap conversion.
- Because `ramp` saturates, every pixel has latched by the 256th ramp cycle.
- A saturated `acc` (integer part 255) yields sample 255.
- A pixel that has already latched ignores later ramp cycles until the next erase.
- Expose concurrent with `ana_ramp` is legal: integration and comparison use the pre-edge values.

## Timing
- Reset, asynchronous, clears everything: `acc`, `sample`, `done`, `ramp`, `out_data` = 0. After reset is released, the next clk edge operates normally.
- Reset mid-exposure or mid-conversion discards all data.
- Erase takes 1 cycle.
- Exposure: after N strobes, `acc` = N·DV_PIXEL_Q8, saturated.
- Conversion latency: the code equals the number of ramp cycles preceding the latch. The sample is valid at the edge on which `ramp` first reaches `acc[15:8]`.
- Read latency: 1 cycle from `read`/`row_pointer` to `out_data`.
- No handshakes; the sequencer guarantees phase order erase → expose → convert → read.
- Erase overrides any simultaneous expose or convert.

## Structure
- Package `pixel_array_pkg`:
  - `ACC_W`=16, `DATA_W`=8, `RAMP_MAX`=8'hFF.
  - Typedef `pixel_data_t` (logic [7:0]).
- Sub-module `pixel_cell`:
  - Holds `acc`, `sample`, `done`.
  - Inputs: clear, integrate, DV, ramp value, ramp_valid.
  - Output: sample.
  - Instantiated ROWS times by a generate loop.
- Top level holds the ramp counter, the read mux, and the output register.

## Test plan
- **Reset.** Assert reset mid-exposure → `out_data`=0; read of any row after release returns 0.
- **Nominal frame.** DV_PIXEL_Q8=128; erase 5 cycles; 255 expose/bias strobes; 255 ramp cycles; read row 0 then row 1 → `out_data`=127 for both, 1 cycle after each read select.
- **Saturation.** DV_PIXEL_Q8=255, 300 exposure strobes → `acc`=0xFFFF; conversion → sample 255.
- **Dark pixel.** Erase, zero exposure strobes, convert → sample 0, latched on the first ramp cycle.
- **Erase priority.** Erase and expose asserted together, then erase with `ana_reset`=0 → the first cycle leaves `acc`=0; the second erase is ignored and `acc` is retained.
- **Readout gating.** `read`=0 → `out_data`=0; `read`=1 with an out-of-range row_pointer (ROWS=3, pointer 3) → 0; interrupting the ramp (`ana_ramp` low) resets `ramp` to 0 without changing already-latched samples.

Source files
------------

// File: rtl/pixel_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_array_pkg
// Description : Shared widths, types and helpers for the pixel sensor array.
//               ACC_W    - width of the 8.8 fixed-point photo accumulator
//               DATA_W   - width of ramp, samples and read data
//               RAMP_MAX - saturation value of the shared ramp counter
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_array_pkg;

  localparam int          ACC_W    = 16;
  localparam int          DATA_W   = 8;
  localparam logic [7:0]  RAMP_MAX = 8'hFF;

  typedef logic [DATA_W-1:0] pixel_data_t;

  // Add one exposure increment to an accumulator, clamping at all-ones
  // instead of wrapping so an over-exposed pixel reads full scale.
  function automatic logic [ACC_W-1:0] acc_sat_add(input logic [ACC_W-1:0] acc,
                                                   input pixel_data_t      dv);
    logic [ACC_W:0] w_sum;
    w_sum = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, dv};
    return w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  endfunction

endpackage : pixel_array_pkg
`default_nettype wire

// File: rtl/pixel_sensor_array_cell.sv
`default_nettype none
// ============================================================================
// Module      : pixel_cell
// Description : One pixel: integrates exposure pulses into an 8.8 fixed-point
//               accumulator and latches the shared ramp value the first time
//               the ramp reaches the accumulator's integer part.
// Ports       : clk, reset    - clock, asynchronous active-high reset
//               clear         - erase accumulator, sample and done flag
//               integrate     - add dv to the accumulator this edge
//               dv            - photocurrent per pulse (0.8 fraction)
//               ramp          - current (pre-increment) shared ramp value
//               ramp_valid    - a conversion cycle is in progress
//               sample        - latched conversion code
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_cell
  import pixel_array_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        integrate,
  input  pixel_data_t dv,
  input  pixel_data_t ramp,
  input  logic        ramp_valid,
  output pixel_data_t sample
);

  logic [ACC_W-1:0] r_acc;
  pixel_data_t      r_sample;
  logic             r_done;

  // Integration and comparison both see the pre-edge accumulator, so an
  // exposure pulse landing during conversion only affects later cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_sample <= '0;
      r_done   <= 1'b0;
    end else if (clear) begin
      r_acc    <= '0;
      r_sample <= '0;
      r_done   <= 1'b0;
    end else begin
      if (integrate) begin
        r_acc <= acc_sat_add(r_acc, dv);
      end
      if (ramp_valid && !r_done && (ramp >= r_acc[ACC_W-1:ACC_W-DATA_W])) begin
        r_sample <= ramp;
        r_done   <= 1'b1;
      end
    end
  end

  assign sample = r_sample;

endmodule : pixel_cell
`default_nettype wire

// File: rtl/pixel_sensor_array.sv
`default_nettype none
// ============================================================================
// Module      : pixel_sensor_array
// Description : Array of ROWS pixels sharing one single-slope ramp ADC, with
//               a registered one-row-at-a-time readout.
// Ports       : clk, reset   - clock, asynchronous active-high reset
//               ana_bias1    - exposure strobe
//               ana_ramp     - conversion strobe (low clears the ramp)
//               ana_reset    - erase enable
//               erase        - clear all pixels (when ana_reset is high)
//               expose       - exposure window
//               read         - readout enable
//               row_pointer  - row to read
//               out_data     - registered read data (0 when idle/out of range)
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_sensor_array
  import pixel_array_pkg::*;
#(
  parameter int ROWS        = 2,
  parameter int DV_PIXEL_Q8 = 128,
  parameter int RP_W        = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ana_bias1,
  input  logic            ana_ramp,
  input  logic            ana_reset,
  input  logic            erase,
  input  logic            expose,
  input  logic            read,
  input  logic [RP_W-1:0] row_pointer,
  output logic [7:0]      out_data
);

  localparam int          NUM_SLOTS = 2 ** RP_W;
  localparam pixel_data_t C_DV      = DV_PIXEL_Q8[DATA_W-1:0];

  logic        w_clear;
  logic        w_integrate;
  pixel_data_t r_ramp;
  pixel_data_t r_out_data;
  pixel_data_t w_sample [NUM_SLOTS];

  // Erase wins over everything; the cells apply the same priority locally.
  assign w_clear     = erase & ana_reset;
  assign w_integrate = expose & ana_bias1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ramp <= '0;
    end else if (w_clear || !ana_ramp) begin
      r_ramp <= '0;
    end else if (r_ramp != RAMP_MAX) begin
      r_ramp <= r_ramp + 8'd1;
    end
  end

  // Every pointer code gets a slot; codes past the last row read as zero so
  // the read mux needs no separate range check.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_row
    if (g < ROWS) begin : g_cell
      pixel_cell u_cell (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .integrate  (w_integrate),
        .dv         (C_DV),
        .ramp       (r_ramp),
        .ramp_valid (ana_ramp),
        .sample     (w_sample[g])
      );
    end else begin : g_empty
      assign w_sample[g] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data <= '0;
    end else begin
      r_out_data <= read ? w_sample[row_pointer] : '0;
    end
  end

  assign out_data = r_out_data;

endmodule : pixel_sensor_array
`default_nettype wire

// File: tb/tb_pixel_sensor_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_sensor_array
// Description : Self-checking bench for pixel_sensor_array (ROWS=3 so that an
//               out-of-range row pointer exists). Directed frames from the
//               test plan plus random frames checked against a frame-level
//               reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_sensor_array;

  localparam int ROWS = 3;
  localparam int DV   = 128;
  localparam int RP_W = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ana_bias1 = 1'b0;
  logic            ana_ramp = 1'b0;
  logic            ana_reset = 1'b0;
  logic            erase = 1'b0;
  logic            expose = 1'b0;
  logic            read = 1'b0;
  logic [RP_W-1:0] row_pointer = '0;
  logic [7:0]      out_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: all pixels see the same exposure, so one set of
  // per-pixel quantities describes every row.
  int m_acc, m_sample, m_ramp, m_out;
  bit m_done;

  pixel_sensor_array #(
    .ROWS        (ROWS),
    .DV_PIXEL_Q8 (DV),
    .RP_W        (RP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ana_bias1   (ana_bias1),
    .ana_ramp    (ana_ramp),
    .ana_reset   (ana_reset),
    .erase       (erase),
    .expose      (expose),
    .read        (read),
    .row_pointer (row_pointer),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_sample = 0; m_done = 0; m_ramp = 0; m_out = 0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge values.
  task automatic model_edge();
    int code;
    m_out = (read && int'(row_pointer) < ROWS) ? m_sample : 0;
    if (erase && ana_reset) begin
      m_acc = 0; m_sample = 0; m_done = 0; m_ramp = 0;
    end else begin
      code = m_acc / 256;
      if (ana_ramp) begin
        if (!m_done && m_ramp >= code) begin
          m_sample = m_ramp;
          m_done   = 1;
        end
        m_ramp = (m_ramp < 255) ? m_ramp + 1 : 255;
      end else begin
        m_ramp = 0;
      end
      if (expose && ana_bias1)
        m_acc = (m_acc + DV > 65535) ? 65535 : m_acc + DV;
    end
  endtask

  task automatic drive(input bit e, input bit ar, input bit ex, input bit b1,
                       input bit ra, input bit rd, input int rp);
    erase = e; ana_reset = ar; expose = ex; ana_bias1 = b1;
    ana_ramp = ra; read = rd; row_pointer = rp[RP_W-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("cycle", out_data, m_out[7:0]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_row(input int rp, input logic [7:0] exp, input string tag);
    drive(0, 0, 0, 0, 0, 1, rp);
    tick();
    check_eq(tag, out_data, exp);
  endtask

  initial begin
    model_reset();
    #1;
    check_eq("reset_out", out_data, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Nominal frame.
    drive(1, 1, 0, 0, 0, 0, 0); run(5);
    drive(0, 0, 1, 1, 0, 0, 0); run(255);
    drive(0, 0, 0, 0, 1, 0, 0); run(255);
    read_row(0, 8'd127, "nominal_row0");
    read_row(1, 8'd127, "nominal_row1");
    read_row(2, 8'd127, "nominal_row2");

    // Readout gating.
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    check_eq("read_low", out_data, 8'h00);
    read_row(3, 8'h00, "row_out_of_range");

    // Ramp interruption keeps latched samples.
    drive(0, 0, 0, 0, 0, 1, 1); run(3);
    drive(0, 0, 0, 0, 1, 1, 1); run(20);
    check_eq("ramp_interrupt", out_data, 8'd127);

    // Asynchronous reset mid-exposure.
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0, 1, 0); run(10);
    #2 reset = 1'b1;
    model_reset();
    #1 check_eq("reset_async", out_data, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    read_row(0, 8'h00, "post_reset_row0");
    read_row(1, 8'h00, "post_reset_row1");

    // Dark pixel: latches 0 on the first ramp cycle.
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    read_row(0, 8'h00, "dark_pixel");

    // Saturation: 600 strobes of 0.5 LSB overflow 0xFFFF; needs ramp = 255.
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0, 0, 0); run(600);
    drive(0, 0, 0, 0, 1, 0, 0); run(255);
    read_row(1, 8'h00, "sat_not_yet");
    drive(0, 0, 0, 0, 1, 0, 0); run(256);
    read_row(1, 8'd255, "saturation");

    // Erase priority: erase wins over expose; erase without ana_reset ignored.
    drive(1, 1, 1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0, 0, 0); run(10);
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0); run(20);
    read_row(2, 8'd5, "erase_priority");

    // Random frames.
    for (int f = 0; f < 20; f++) begin
      int n;
      drive(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1), 1, $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 3));
      run($urandom_range(1, 3));
      n = $urandom_range(0, 700);
      for (int i = 0; i < n; i++) begin
        drive(0, $urandom_range(0, 1), $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 1), $urandom_range(0, 3));
        tick();
      end
      n = $urandom_range(0, 300);
      for (int i = 0; i < n; i++) begin
        drive(0, $urandom_range(0, 1), $urandom_range(0, 3) == 0, 1,
              $urandom_range(0, 29) != 0, $urandom_range(0, 1), $urandom_range(0, 3));
        tick();
      end
      for (int r = 0; r < 4; r++) begin
        drive(0, 0, 0, 0, 0, 1, r);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pixel_sensor_array
`default_nettype wire
